// File: rtl/crd_drop_if.sv
// ----------------------------------------------------------------------------
// crd_drop_if
// One ready/valid token stream as used by the coordinate-drop primitive.
//   data  : token (bit 16 = control flag, low bits = coordinate or stop level)
//   valid : producer has a token on data
//   ready : consumer can take the token this cycle
// Modports:
//   master : drives data/valid, observes ready (producer side)
//   slave  : observes data/valid, drives ready (consumer side)
// ----------------------------------------------------------------------------
interface crd_drop_if #(
    parameter int DATA_WIDTH = 17
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/crd_drop.sv
// ----------------------------------------------------------------------------
// crd_drop
// Sparse-pipeline coordinate-drop primitive. Consumes an outer coordinate
// stream and its inner coordinate stream, deletes every outer coordinate whose
// inner fiber is empty and, in cmrg_mode, merges the stop tokens left behind by
// the dropped fibers into a single pending stop (highest level wins).
// Ports:
//   clk          : rising-edge clock
//   flush        : synchronous active-high reset, clears FIFOs, FSM, pending stop
//   rst_n        : compatibility input, no functional effect
//   clk_en       : 0 freezes all state and blocks every handshake
//   tile_en      : 0 forces every ready/valid output low and freezes state
//   cmrg_mode    : 1 = merge inner stops of dropped fibers, 0 = inner passes as is
//   coord_in_0   : outer coordinate stream (slave)
//   coord_in_1   : inner coordinate stream (slave)
//   coord_out_0  : filtered outer stream (master)
//   coord_out_1  : filtered inner stream (master)
// Every port is buffered by a FIFO_DEPTH-entry FIFO; outputs come straight from
// FIFO storage so they are registered and stay stable until accepted.
// ----------------------------------------------------------------------------
module crd_drop #(
    parameter int DATA_WIDTH = 17,
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       flush,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       tile_en,
    input  logic       cmrg_mode,
    crd_drop_if.slave  coord_in_0,
    crd_drop_if.slave  coord_in_1,
    crd_drop_if.master coord_out_0,
    crd_drop_if.master coord_out_1
);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int NUM_FIFO = 4;
    localparam logic [DATA_WIDTH-1:0] DONE_TOK = DATA_WIDTH'(17'h10100);

    typedef enum logic [1:0] {
        ST_START      = 2'd0,
        ST_HOLD_OUTER = 2'd1,
        ST_PASS_INNER = 2'd2,
        ST_DONE_WAIT  = 2'd3
    } state_e;

    function automatic logic is_ctrl(input logic [DATA_WIDTH-1:0] tok);
        return tok[16];
    endfunction

    function automatic logic is_done(input logic [DATA_WIDTH-1:0] tok);
        return (tok == DONE_TOK);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] stop_tok(input logic [7:0] lvl);
        logic [DATA_WIDTH-1:0] tok;
        tok       = {DATA_WIDTH{1'b0}};
        tok[16]   = 1'b1;
        tok[7:0]  = lvl;
        return tok;
    endfunction

    function automatic logic [7:0] max_lvl(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // FIFO index map: 0 = outer in, 1 = inner in, 2 = outer out, 3 = inner out
    logic [NUM_FIFO-1:0]                 push_s;
    logic [NUM_FIFO-1:0]                 pop_s;
    logic [NUM_FIFO-1:0]                 full_s;
    logic [NUM_FIFO-1:0]                 empty_s;
    logic [NUM_FIFO-1:0][DATA_WIDTH-1:0] wdata_s;
    logic [NUM_FIFO-1:0][DATA_WIDTH-1:0] rdata_s;

    logic                  en_s;
    logic                  step_s;
    logic                  in0_fire_s;
    logic                  in1_fire_s;
    logic                  out0_fire_s;
    logic                  out1_fire_s;
    logic                  fsm_pop0_s;
    logic                  fsm_pop1_s;
    logic                  fsm_push0_s;
    logic                  fsm_push1_s;
    logic [DATA_WIDTH-1:0] fsm_wdata0_s;
    logic [DATA_WIDTH-1:0] fsm_wdata1_s;
    logic [DATA_WIDTH-1:0] outer_s;
    logic [DATA_WIDTH-1:0] inner_s;

    state_e                state_q;
    state_e                state_d;
    logic [DATA_WIDTH-1:0] coord_q;
    logic [DATA_WIDTH-1:0] coord_d;
    logic                  pend_vld_q;
    logic                  pend_vld_d;
    logic [7:0]            pend_lvl_q;
    logic [7:0]            pend_lvl_d;

    logic                  unused_s;
    assign unused_s = rst_n;

    assign en_s = clk_en & tile_en;

    // Stream handshakes; flush and tile_en hide every ready/valid.
    assign coord_in_0.ready  = ~full_s[0] & tile_en & ~flush;
    assign coord_in_1.ready  = ~full_s[1] & tile_en & ~flush;
    assign coord_out_0.valid = ~empty_s[2] & tile_en & ~flush;
    assign coord_out_1.valid = ~empty_s[3] & tile_en & ~flush;
    assign coord_out_0.data  = rdata_s[2];
    assign coord_out_1.data  = rdata_s[3];

    assign in0_fire_s  = coord_in_0.valid & coord_in_0.ready & clk_en;
    assign in1_fire_s  = coord_in_1.valid & coord_in_1.ready & clk_en;
    assign out0_fire_s = coord_out_0.valid & coord_out_0.ready & clk_en;
    assign out1_fire_s = coord_out_1.valid & coord_out_1.ready & clk_en;

    assign push_s  = {fsm_push1_s, fsm_push0_s, in1_fire_s, in0_fire_s};
    assign pop_s   = {out1_fire_s, out0_fire_s, fsm_pop1_s, fsm_pop0_s};
    assign wdata_s = {fsm_wdata1_s, fsm_wdata0_s, coord_in_1.data, coord_in_0.data};

    assign outer_s = rdata_s[0];
    assign inner_s = rdata_s[1];

    // The FSM only advances when both output FIFOs have room, so a stalled
    // output never leaves an input half-consumed.
    assign step_s = en_s & ~full_s[2] & ~full_s[3];

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [CNT_W-1:0]      count_q;

        assign full_s[g]  = (count_q == CNT_W'(FIFO_DEPTH));
        assign empty_s[g] = (count_q == CNT_W'(0));
        assign rdata_s[g] = mem_q[rd_ptr_q];

        // FIFO storage, pointers and occupancy (push and pop together keep the count).
        always_ff @(posedge clk) begin
            if (flush) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[i] <= {DATA_WIDTH{1'b0}};
                end
                wr_ptr_q <= {PTR_W{1'b0}};
                rd_ptr_q <= {PTR_W{1'b0}};
                count_q  <= {CNT_W{1'b0}};
            end else begin
                if (push_s[g]) begin
                    mem_q[wr_ptr_q] <= wdata_s[g];
                    wr_ptr_q        <= next_ptr(wr_ptr_q);
                end
                if (pop_s[g]) begin
                    rd_ptr_q <= next_ptr(rd_ptr_q);
                end
                case ({push_s[g], pop_s[g]})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FSM state, latched outer coordinate and pending merged stop.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q    <= ST_START;
            coord_q    <= {DATA_WIDTH{1'b0}};
            pend_vld_q <= 1'b0;
            pend_lvl_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            coord_q    <= coord_d;
            pend_vld_q <= pend_vld_d;
            pend_lvl_q <= pend_lvl_d;
        end
    end

    // Next-state and FIFO push/pop decisions for one token step.
    always_comb begin
        state_d      = state_q;
        coord_d      = coord_q;
        pend_vld_d   = pend_vld_q;
        pend_lvl_d   = pend_lvl_q;
        fsm_pop0_s   = 1'b0;
        fsm_pop1_s   = 1'b0;
        fsm_push0_s  = 1'b0;
        fsm_push1_s  = 1'b0;
        fsm_wdata0_s = {DATA_WIDTH{1'b0}};
        fsm_wdata1_s = {DATA_WIDTH{1'b0}};
        if (step_s) begin
            case (state_q)
                ST_START: begin
                    if (!empty_s[0]) begin
                        fsm_pop0_s = 1'b1;
                        if (!is_ctrl(outer_s)) begin
                            // Coordinate is held until its fiber proves non-empty.
                            coord_d = outer_s;
                            state_d = ST_HOLD_OUTER;
                        end else if (is_done(outer_s)) begin
                            state_d = ST_DONE_WAIT;
                        end else begin
                            fsm_push0_s  = 1'b1;
                            fsm_wdata0_s = outer_s;
                        end
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_HOLD_OUTER, ST_PASS_INNER, ST_DONE_WAIT: begin
                    if (!empty_s[1]) begin
                        if (!is_ctrl(inner_s)) begin
                            if (pend_vld_q) begin
                                // A merged stop must precede the next inner data.
                                fsm_push1_s  = 1'b1;
                                fsm_wdata1_s = stop_tok(pend_lvl_q);
                                pend_vld_d   = 1'b0;
                            end else begin
                                fsm_push1_s  = 1'b1;
                                fsm_wdata1_s = inner_s;
                                fsm_pop1_s   = 1'b1;
                                if (state_q == ST_HOLD_OUTER) begin
                                    fsm_push0_s  = 1'b1;
                                    fsm_wdata0_s = coord_q;
                                    state_d      = ST_PASS_INNER;
                                end else begin
                                    state_d = state_q;
                                end
                            end
                        end else if (!is_done(inner_s)) begin
                            fsm_pop1_s = 1'b1;
                            if (cmrg_mode) begin
                                pend_vld_d = 1'b1;
                                pend_lvl_d = pend_vld_q ? max_lvl(pend_lvl_q, inner_s[7:0])
                                                        : inner_s[7:0];
                            end else begin
                                fsm_push1_s  = 1'b1;
                                fsm_wdata1_s = inner_s;
                            end
                            // Stop ends the fiber; a held coordinate is dropped here.
                            if (state_q != ST_DONE_WAIT) begin
                                state_d = ST_START;
                            end else begin
                                state_d = ST_DONE_WAIT;
                            end
                        end else if (state_q == ST_DONE_WAIT) begin
                            if (pend_vld_q) begin
                                fsm_push1_s  = 1'b1;
                                fsm_wdata1_s = stop_tok(pend_lvl_q);
                                pend_vld_d   = 1'b0;
                            end else begin
                                fsm_push0_s  = 1'b1;
                                fsm_wdata0_s = DONE_TOK;
                                fsm_push1_s  = 1'b1;
                                fsm_wdata1_s = DONE_TOK;
                                fsm_pop1_s   = 1'b1;
                                state_d      = ST_START;
                            end
                        end else begin
                            // Inner done without a closing stop: give up the fiber
                            // and leave done for the outer done to consume.
                            state_d = ST_START;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end
endmodule

// File: tb/tb_crd_drop.sv
// ----------------------------------------------------------------------------
// tb_crd_drop
// Self-checking bench for crd_drop: directed tiles with literal expectations,
// randomized multi-tile streams with throttling, and a mid-tile flush.
// Expected streams come from a list-level model of the drop/merge rules.
// ----------------------------------------------------------------------------
module tb_crd_drop;
    typedef logic [16:0] tok_q_t[$];

    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;

    logic clk       = 1'b0;
    logic flush     = 1'b1;
    logic rst_n     = 1'b1;
    logic clk_en    = 1'b1;
    logic tile_en   = 1'b1;
    logic cmrg_mode = 1'b0;

    crd_drop_if #(.DATA_WIDTH(17)) in0_if ();
    crd_drop_if #(.DATA_WIDTH(17)) in1_if ();
    crd_drop_if #(.DATA_WIDTH(17)) out0_if ();
    crd_drop_if #(.DATA_WIDTH(17)) out1_if ();

    crd_drop #(.DATA_WIDTH(17), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .flush      (flush),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .tile_en    (tile_en),
        .cmrg_mode  (cmrg_mode),
        .coord_in_0 (in0_if),
        .coord_in_1 (in1_if),
        .coord_out_0(out0_if),
        .coord_out_1(out1_if)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    bit     chk_en   = 1'b0;
    bit     throttle = 1'b0;
    bit     tile_off = 1'b0;
    bit     abort    = 1'b0;
    tok_q_t src0, src1, m0, m1, exp0, exp1;
    tok_q_t lo, li, le0, le1;
    bit     prev_stall [2];
    logic [16:0] prev_data [2];

    // List-level model: walk outer tokens, consume each fiber, merge stops.
    function automatic void run_model(input bit cm);
        int          j;
        bit          pv;
        bit          emitted;
        logic [7:0]  pl;
        logic [16:0] c;
        logic [16:0] t;
        j  = 0;
        pv = 1'b0;
        pl = 8'd0;
        m0.delete();
        m1.delete();
        for (int i = 0; i < src0.size(); i++) begin
            c = src0[i];
            if (!c[16]) begin
                emitted = 1'b0;
                while (j < src1.size()) begin
                    t = src1[j];
                    if (t == DN) break;
                    j++;
                    if (!t[16]) begin
                        if (!emitted) begin m0.push_back(c); emitted = 1'b1; end
                        if (pv) begin m1.push_back(S0 | {9'd0, pl}); pv = 1'b0; end
                        m1.push_back(t);
                    end else begin
                        if (cm) begin
                            pl = (pv && pl > t[7:0]) ? pl : t[7:0];
                            pv = 1'b1;
                        end else begin
                            m1.push_back(t);
                        end
                        break;
                    end
                end
            end else if (c == DN) begin
                while (j < src1.size() && src1[j] != DN) j++;
                j++;
                if (pv) begin m1.push_back(S0 | {9'd0, pl}); pv = 1'b0; end
                m0.push_back(DN);
                m1.push_back(DN);
            end else begin
                m0.push_back(c);
            end
        end
    endfunction

    function automatic void gen_tile();
        int nf;
        int len;
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) begin
            if ($urandom_range(0, 3) == 0) src0.push_back(S0 | 17'($urandom_range(0, 2)));
            src0.push_back(17'($urandom_range(0, 65535)));
            len = $urandom_range(0, 3);
            for (int k = 0; k < len; k++) src1.push_back(17'($urandom_range(0, 65535)));
            src1.push_back(S0 | 17'($urandom_range(0, 3)));
        end
        if ($urandom_range(0, 1) == 1) src0.push_back(S0);
        src0.push_back(DN);
        src1.push_back(DN);
    endfunction

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic check_q(input string name, input tok_q_t got, input tok_q_t want);
        int idx;
        idx = -1;
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            if (idx < 0 && got[i] !== want[i]) idx = i;
        end
        if (idx < 0 && got.size() != want.size()) idx = (got.size() < want.size()) ? got.size() : want.size();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL %s: model differs at index %0d (model %0d tokens, literal %0d tokens, model %h, required %h)",
                     name, idx, got.size(), want.size(),
                     (idx < got.size()) ? got[idx] : 17'h0, (idx < want.size()) ? want[idx] : 17'h0);
        end
    endtask

    task automatic drive0(input int thr);
        int idx;
        int guard;
        bit fire;
        idx   = 0;
        guard = 0;
        while (idx < src0.size() && guard < 5000 && !abort) begin
            in0_if.valid = ($urandom_range(0, 99) < thr);
            in0_if.data  = src0[idx];
            @(negedge clk);
            fire = in0_if.valid && in0_if.ready && clk_en && tile_en;
            @(posedge clk); #1;
            if (fire) idx++;
            guard++;
        end
        in0_if.valid = 1'b0;
        if (!abort) begin
            checks++;
            if (idx != src0.size()) begin
                failures++;
                $display("FAIL in0_accept: accepted %0d tokens, required %0d", idx, src0.size());
            end
        end
    endtask

    task automatic drive1(input int thr);
        int idx;
        int guard;
        bit fire;
        idx   = 0;
        guard = 0;
        while (idx < src1.size() && guard < 5000 && !abort) begin
            in1_if.valid = ($urandom_range(0, 99) < thr);
            in1_if.data  = src1[idx];
            @(negedge clk);
            fire = in1_if.valid && in1_if.ready && clk_en && tile_en;
            @(posedge clk); #1;
            if (fire) idx++;
            guard++;
        end
        in1_if.valid = 1'b0;
        if (!abort) begin
            checks++;
            if (idx != src1.size()) begin
                failures++;
                $display("FAIL in1_accept: accepted %0d tokens, required %0d", idx, src1.size());
            end
        end
    endtask

    task automatic play(input bit thr);
        int cyc;
        throttle = thr;
        fork
            drive0(thr ? 60 : 100);
            drive1(thr ? 60 : 100);
        join
        cyc = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++;
            $display("FAIL drain: out0 still owes %0d, out1 still owes %0d, required 0 and 0",
                     exp0.size(), exp1.size());
        end
        exp0.delete();
        exp1.delete();
        throttle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input bit cm);
        src0 = lo;
        src1 = li;
        run_model(cm);
        check_q({name, "_model_out0"}, m0, le0);
        check_q({name, "_model_out1"}, m1, le1);
        cmrg_mode = cm;
        exp0 = le0;
        exp1 = le1;
        play(1'b0);
    endtask

    task automatic check_out(input int p, input logic v, input logic r, input logic [16:0] d);
        bit          fire;
        bit          have;
        logic [16:0] want;
        if (prev_stall[p] && tile_en) begin
            checks++;
            if (!(v && d === prev_data[p])) begin
                failures++;
                $display("FAIL out%0d_stable: got valid=%0b data=%h, required valid=1 data=%h",
                         p, v, d, prev_data[p]);
            end
        end
        fire = v && r && clk_en && tile_en;
        if (fire) begin
            checks++;
            have = (p == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
            if (!have) begin
                failures++;
                $display("FAIL out%0d_unexpected: got %h, required no token", p, d);
            end else begin
                if (p == 0) want = exp0.pop_front();
                else        want = exp1.pop_front();
                if (d !== want) begin
                    failures++;
                    $display("FAIL out%0d_token: got %h, required %h", p, d, want);
                end
            end
        end
        prev_stall[p] = v && !fire;
        prev_data[p]  = d;
    endtask

    // Scoreboard: predicts each output transfer before the edge it completes on.
    always @(negedge clk) begin
        if (chk_en && !flush) begin
            check_out(0, out0_if.valid, out0_if.ready, out0_if.data);
            check_out(1, out1_if.valid, out1_if.ready, out1_if.data);
        end else begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end
    end

    // Downstream ready and enable throttling.
    initial begin
        out0_if.ready = 1'b1;
        out1_if.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (throttle) begin
                out0_if.ready = ($urandom_range(0, 99) < 60);
                out1_if.ready = ($urandom_range(0, 99) < 60);
                clk_en        = ($urandom_range(0, 99) < 90);
                tile_en       = ($urandom_range(0, 99) < 90);
            end else begin
                out0_if.ready = 1'b1;
                out1_if.ready = 1'b1;
                clk_en        = 1'b1;
                tile_en       = !tile_off;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int d1;
        in0_if.valid = 1'b0;
        in0_if.data  = 17'h0;
        in1_if.valid = 1'b0;
        in1_if.data  = 17'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in0_ready",   {16'd0, in0_if.ready},  17'h0);
        chk("rst_in1_ready",   {16'd0, in1_if.ready},  17'h0);
        chk("rst_out0_valid",  {16'd0, out0_if.valid}, 17'h0);
        chk("rst_out1_valid",  {16'd0, out1_if.valid}, 17'h0);
        chk("rst_out0_data",   out0_if.data, 17'h0);
        chk("rst_out1_data",   out1_if.data, 17'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_in0_ready", {16'd0, in0_if.ready}, 17'h1);
        chk("post_flush_in1_ready", {16'd0, in1_if.ready}, 17'h1);
        tile_off = 1'b1;
        repeat (2) @(negedge clk);
        chk("tile_off_in0_ready", {16'd0, in0_if.ready}, 17'h0);
        chk("tile_off_in1_ready", {16'd0, in1_if.ready}, 17'h0);
        tile_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        lo  = '{17'h0, 17'h1, 17'h2, S0, DN};
        li  = '{17'h5, S0, S0, 17'h7, 17'h8, S1, DN};
        le0 = '{17'h0, 17'h2, S0, DN};
        le1 = '{17'h5, S0, 17'h7, 17'h8, S1, DN};
        directed("basic_drop", 1'b1);

        lo  = '{17'h0, 17'h1, S0, DN};
        li  = '{17'h4, S0, S1, DN};
        le0 = '{17'h0, S0, DN};
        le1 = '{17'h4, S1, DN};
        directed("last_empty_merge", 1'b1);

        le1 = '{17'h4, S0, S1, DN};
        directed("last_empty_nomerge", 1'b0);

        lo  = '{17'h3, S0, DN};
        li  = '{S1, DN};
        le0 = '{S0, DN};
        le1 = '{S1, DN};
        directed("all_empty", 1'b1);

        for (int r = 0; r < 2; r++) begin
            src0.delete();
            src1.delete();
            repeat (4) gen_tile();
            run_model(r == 0);
            d0 = 0;
            d1 = 0;
            foreach (m0[k]) if (m0[k] == DN) d0++;
            foreach (m1[k]) if (m1[k] == DN) d1++;
            chk("model_done_out0", 17'(d0), 17'd4);
            chk("model_done_out1", 17'(d1), 17'd4);
            cmrg_mode = (r == 0);
            exp0 = m0;
            exp1 = m1;
            play(1'b0);
            exp0 = m0;
            exp1 = m1;
            play(1'b1);
        end

        // Mid-tile flush: stream part of a long tile, flush, then a clean tile.
        chk_en = 1'b0;
        src0.delete();
        src1.delete();
        for (int f = 0; f < 6; f++) begin
            src0.push_back(17'(f + 16));
            for (int k = 0; k < 3; k++) src1.push_back(17'(100 + f * 3 + k));
            src1.push_back(S1);
        end
        src0.push_back(DN);
        src1.push_back(DN);
        cmrg_mode = 1'b1;
        abort     = 1'b0;
        fork
            drive0(100);
            drive1(100);
            begin
                repeat (5) @(posedge clk);
                abort = 1'b1;
            end
        join
        flush = 1'b1;
        repeat (2) @(negedge clk);
        chk("flush_in0_ready", {16'd0, in0_if.ready}, 17'h0);
        chk("flush_in1_ready", {16'd0, in1_if.ready}, 17'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        abort = 1'b0;
        exp0.delete();
        exp1.delete();
        @(posedge clk); #1;
        chk_en = 1'b1;

        lo  = '{17'h0, 17'h1, S0, DN};
        li  = '{17'h4, S0, S1, DN};
        le0 = '{17'h0, S0, DN};
        le1 = '{17'h4, S1, DN};
        directed("after_flush", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
